// File: rtl/spi_bus_master.sv
// spi_bus_master: mode-0 SPI word master with chip-select hold across bursts and a JTAG bus override
//
// Ports:
//   i_clk, i_rst          clock (rising edge) and synchronous active-high reset
//   i_start               start a transfer; taken only while o_busy is low
//   i_wdata, i_csSel,     word, chip-select index and CS-hold flag, latched when a start is taken
//   i_hold
//   i_release             drop a held chip select while idle
//   o_busy                transfer running, or JTAG owns the bus
//   o_done, o_rdata       one-cycle completion pulse and the received word
//   i_jtagSpiEn           JTAG takes the pins while high
//   i_jtagClk, i_jtagMosi, i_jtagCSn   pin values driven while JTAG owns the bus
//   o_spiCLK, o_spiMOSI,  SPI pins (SCLK idles low, MSB first)
//   i_spiMISO, o_spiCSn
module spi_bus_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 2,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [CS_W-1:0]   i_csSel,
    input  logic              i_hold,
    input  logic              i_release,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_jtagSpiEn,
    input  logic              i_jtagClk,
    input  logic              i_jtagMosi,
    input  logic              i_jtagCSn,
    output logic              o_spiCLK,
    output logic              o_spiMOSI,
    input  logic              i_spiMISO,
    output logic [NUM_CS-1:0] o_spiCSn
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, HELD, SETUP, HIGH, LOW, TAIL, DONE} stateT;

    stateT             state, nextState;
    logic [CNT_W-1:0]  divCnt;
    logic [BIT_W-1:0]  bitCnt;
    logic [DATA_W-1:0] txShift, rxShift;
    logic [CS_W-1:0]   csSelQ;
    logic              holdQ, divLast, bitLast, idleLike, accept, csActive;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        divLast   = divCnt == CNT_W'(CLK_DIV - 1);
        bitLast   = bitCnt == BIT_W'(DATA_W - 1);
        // DONE counts as idle so a start in the completion cycle is taken
        idleLike  = state == IDLE || state == HELD || state == DONE;
        accept    = idleLike && i_start && !i_jtagSpiEn;
        nextState = state;
        case (state)
            IDLE:    nextState = i_start ? SETUP : IDLE;
            HELD:    nextState = i_start ? SETUP : (i_release ? IDLE : HELD);
            SETUP:   nextState = divLast ? HIGH : SETUP;
            HIGH:    nextState = divLast ? (bitLast ? TAIL : LOW) : HIGH;
            LOW:     nextState = divLast ? HIGH : LOW;
            TAIL:    nextState = divLast ? DONE : TAIL;
            DONE:    nextState = i_start ? SETUP : (holdQ ? HELD : IDLE);
            default: nextState = IDLE;
        endcase
        if (i_jtagSpiEn) nextState = IDLE;
        // a held CS stays low through DONE so a burst sees no CS glitch
        csActive  = !idleLike || state == HELD || (state == DONE && holdQ);
        o_busy    = !idleLike || i_jtagSpiEn;
        o_done    = state == DONE;
        o_spiCLK  = i_jtagSpiEn ? i_jtagClk : (state == HIGH);
        o_spiMOSI = i_jtagSpiEn ? i_jtagMosi : (!idleLike && txShift[DATA_W-1]);
        o_spiCSn  = '1;
        if (i_jtagSpiEn) o_spiCSn[0] = i_jtagCSn;
        else for (int i = 0; i < NUM_CS; i++) o_spiCSn[i] = !(csActive && csSelQ == CS_W'(i));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            divCnt  <= '0;
            bitCnt  <= '0;
            txShift <= '0;
            rxShift <= '0;
            csSelQ  <= '0;
            holdQ   <= 1'b0;
            o_rdata <= '0;
        end else begin
            divCnt <= (nextState != state) ? '0 : divCnt + CNT_W'(1);
            if (accept) begin
                txShift <= i_wdata;
                csSelQ  <= i_csSel;
                holdQ   <= i_hold;
                bitCnt  <= '0;
            end
            if (state == HIGH && nextState == LOW) begin
                txShift <= {txShift[DATA_W-2:0], 1'b0};
                bitCnt  <= bitCnt + BIT_W'(1);
            end
            // MISO is captured on the edge that raises SCLK
            if (nextState == HIGH && state != HIGH) rxShift <= {rxShift[DATA_W-2:0], i_spiMISO};
            if (state == TAIL && nextState == DONE) o_rdata <= rxShift;
        end
    end
endmodule
